// File: rtl/edge_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : edge_frame_collector
// Brief    : Collects interior 3x3 edge-filter results into a (W-2)x(H-2)
//            frame RAM and exposes it through a 1-cycle read port until
//            the consumer acknowledges. Optional macro EDGE_COLLECT_STATS_EN
//            adds a saturated-pixel counter output (sat_count).
// Revision : 1.0 - initial release
// ============================================================================
module edge_frame_collector #(
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        filt_pixel,
    output logic              frame_ready,
    input  logic              frame_ack,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              overflow
`ifdef EDGE_COLLECT_STATS_EN
    ,
    output logic [ADDR_W:0]   sat_count
`endif
);

    localparam int c_CW    = $clog2(IMAGE_WIDTH);
    localparam int c_RW    = $clog2(IMAGE_HEIGHT);
    localparam int c_DEPTH = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2);

    localparam logic [c_CW-1:0]   c_NC_MAX = c_CW'(IMAGE_WIDTH - 1);
    localparam logic [c_RW-1:0]   c_NR_MAX = c_RW'(IMAGE_HEIGHT - 1);
    localparam logic [c_CW-1:0]   c_NC_TWO = c_CW'(2);
    localparam logic [c_RW-1:0]   c_NR_TWO = c_RW'(2);
    localparam logic [ADDR_W:0]   c_DEPTH_V = (ADDR_W + 1)'(c_DEPTH);
    localparam logic [ADDR_W-1:0] c_WPTR_ONE = ADDR_W'(1);

    localparam logic [0:0] c_ST_COLLECT = 1'b0;
    localparam logic [0:0] c_ST_DONE    = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [c_RW-1:0]   r_nr;
    logic [c_CW-1:0]   r_nc;
    logic [ADDR_W-1:0] r_wptr;
    logic              r_pend;
    logic              r_pend_last;
    logic              r_overflow;
    logic [7:0]        r_rd_data;
    logic              r_rd_valid;
    logic [7:0]        r_ram [c_DEPTH];

    logic w_accept;
    logic w_write;
    logic w_last_write;
    logic w_rd_accept;
    logic w_nc_wrap;

    assign w_accept     = in_valid && (r_state == c_ST_COLLECT);
    assign w_write      = r_pend && !rst;
    assign w_last_write = w_write && r_pend_last;
    assign w_rd_accept  = rd_en && (r_state == c_ST_DONE);
    assign w_nc_wrap    = (r_nc == c_NC_MAX);

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_COLLECT: if (w_last_write) w_state_next = c_ST_DONE;
            c_ST_DONE:    if (frame_ack)    w_state_next = c_ST_COLLECT;
            default:      w_state_next = c_ST_COLLECT;
        endcase
    end

    always_comb begin
        frame_ready = (r_state == c_ST_DONE);
    end

    // ------------------------------------------------------------------
    // Raster position of the newest pixel and the pending-window flag.
    // The window centred one row/column behind is interior when the
    // newest pixel sits at row >= 2 and column >= 2.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nr        <= '0;
            r_nc        <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_pend      <= w_accept && (r_nr >= c_NR_TWO) && (r_nc >= c_NC_TWO);
            r_pend_last <= w_accept && (r_nr == c_NR_MAX) && w_nc_wrap;
            if (w_accept) begin
                if (w_nc_wrap) begin
                    r_nc <= '0;
                    r_nr <= (r_nr == c_NR_MAX) ? '0 : r_nr + c_RW'(1);
                end else begin
                    r_nc <= r_nc + c_CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (w_last_write) begin
            r_wptr <= '0;
        end else if (w_write) begin
            r_wptr <= r_wptr + c_WPTR_ONE;
        end
    end

    // Frame RAM has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_ram[r_wptr] <= filt_pixel;
        end
    end

    // ------------------------------------------------------------------
    // Read port and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                if ({1'b0, rd_addr} < c_DEPTH_V) begin
                    r_rd_data <= r_ram[rd_addr];
                end else begin
                    r_rd_data <= 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid && (r_state == c_ST_DONE)) begin
            r_overflow <= 1'b1;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign overflow = r_overflow;

`ifdef EDGE_COLLECT_STATS_EN
    logic [ADDR_W:0] r_sat_count;

    // Writes only occur in COLLECT, so the count is naturally frozen in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if ((r_state == c_ST_DONE) && frame_ack) begin
            r_sat_count <= '0;
        end else if (w_write && (filt_pixel == 8'hFF)) begin
            r_sat_count <= r_sat_count + (ADDR_W + 1)'(1);
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule
`default_nettype wire

// File: doc/edge_frame_collector.md
Name: edge_frame_collector

Overview:
- Sink for the edge filter's pixel output stream.
- Tracks the raster position of the 3x3 window center alongside the filter's shift registers, and discards border and wrap-around windows.
- Writes each valid interior result into an internal (W-2)x(H-2) frame RAM.
- Once the frame is complete, exposes the RAM through a 1-cycle-latency read port until the consumer acknowledges.

Parameters:
- IMAGE_WIDTH, 8, pixels per input row (W); must be >= 3 and must match the filter instance.
- IMAGE_HEIGHT, 8, rows per input frame (H); must be >= 3.
- ADDR_W, 6, read address width; must be >= clog2((W-2)*(H-2)).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  high at an edge where the filter shifts in a new input pixel; same signal that gates the filter's input_stream.
- filt_pixel  in  8  filter output (output_stream); reflects the window after the most recent shift.
- frame_ready  out  1  frame RAM holds a complete filtered frame.
- frame_ack  in  1  1-cycle pulse from the consumer releasing the frame.
- rd_en  in  1  read request; honoured only while frame_ready=1.
- rd_addr  in  ADDR_W  read address, row-major, 0..(W-2)*(H-2)-1.
- rd_data  out  8  read data.
- rd_valid  out  1  rd_data valid; exactly 1 cycle after an accepted rd_en.
- overflow  out  1  sticky; set when in_valid arrives while frame_ready=1.

Behaviour:
- Reset values: frame_ready=0, rd_valid=0, rd_data=8'h00, overflow=0, state=COLLECT, all counters 0. RAM contents are not cleared.
- Reset mid-frame or mid-readout: same as power-up. A partial frame is abandoned.
- Newest-pixel counters nr (row) and nc (col) track raster order:
  - On in_valid, nc increments; at W-1 it wraps to 0 and nr increments.
  - Counters do not advance without in_valid (gaps allowed).
- Pending flag: at an edge with in_valid, capture pend=1 with the post-shift position (nr,nc) of the pixel just shifted in. Otherwise pend=0.
- Window validity: the center is (nr-1, nc-1). The window is valid iff nr>=2 and nc>=2. No division logic is used.
- Write rule: at the edge after a valid pending window, write filt_pixel to RAM[wptr] and increment wptr.
  - wptr runs 0..(W-2)*(H-2)-1 in row-major order.
  - Write latency is 1 cycle after the in_valid edge.
  - Back-to-back in_valid gives one write per cycle.
- State COLLECT:
  - The write that uses the last pixel (nr=H-1, nc=W-1) moves the FSM to DONE.
  - On that edge, frame_ready goes to 1, nr/nc/wptr reset to 0, and the next frame's counting starts at pixel 0.
- State DONE:
  - frame_ready=1.
  - in_valid is ignored (no count, no write) and sets overflow.
  - rd_en is accepted: next cycle rd_valid=1 and rd_data=RAM[rd_addr].
  - rd_addr >= (W-2)*(H-2) returns rd_data=8'h00 with rd_valid=1.
- frame_ack in DONE: the FSM returns to COLLECT and frame_ready=0 at that edge.
  - An rd_en in the same cycle is still accepted (its rd_valid appears next cycle).
  - An in_valid in the same cycle is dropped and sets overflow.
- frame_ack in COLLECT is ignored. rd_en in COLLECT is ignored (rd_valid=0, rd_data holds its last value).
- overflow clears only on rst.
- Frame output count: (W-2)*(H-2) writes per frame, which is 36 at the defaults.

Optional Feature:
- Macro EDGE_COLLECT_STATS_EN.
- Defined: adds output sat_count [ADDR_W:0].
  - Counts frame writes with filt_pixel==8'hFF.
  - Cleared on rst and at the edge where COLLECT is entered from DONE.
  - Frozen while in DONE.
- Undefined: no sat_count port and no counter logic. All other behaviour is identical.

Test Plan:
- Defaults, 64 consecutive in_valid cycles; bench drives filt_pixel = index of the last shifted pixel (n, 0..63) → 36 writes; frame_ready rises the cycle after pixel 63's write; reads return addr0=18, addr5=23, addr6=26, addr35=63.
- Same frame with one idle cycle inserted after every pixel → identical RAM contents; frame_ready rises one cycle after the final write.
- Read timing: rd_en with rd_addr=7 at edge k → rd_valid=1 with rd_data=27 at k+1 only; rd_addr=40 → rd_data=00, rd_valid=1; rd_en during COLLECT → rd_valid stays 0.
- In DONE, pulse in_valid 3 times, then frame_ack, then a second ramp offset +100 → overflow=1 persists; second-frame addr0=118, which proves the dropped pixels were not counted.
- Assert rst after 30 pixels, then a fresh 64-pixel frame → frame_ready=0 during reset; addr0=18, so no stale position carries over.
- With EDGE_COLLECT_STATS_EN, filt_pixel=8'hFF on every odd n → sat_count=18 at frame_ready; returns to 0 after frame_ack.
